ppi_serializer: RTL and testbench



---
 rtl/ppi_serializer.sv | 141 ++++++++++++++
 tb/tb_ppi_serializer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppi_serializer.sv
// Polyphase interpolator serializer: emits the L phases of one packed word as scaled samples.
// Define PPI_SERIALIZER_SAT_EN to saturate instead of wrap and to add the o_sat flag.
module ppi_serializer #(
  parameter int unsigned gp_interpolation_factor = 32,
  parameter int unsigned gp_phase_width          = 26,
  parameter int unsigned gp_odata_width          = 16,
  parameter int unsigned gp_shift                = 8,
  parameter int unsigned gp_ccw                  = 0
) (
  input  logic                                              i_clk,
  input  logic                                              i_rst,
  input  logic                                              i_ena,
  input  logic                                              i_valid,
  input  logic [gp_phase_width*gp_interpolation_factor-1:0] i_data,
  output logic                                              o_ready,
  output logic                                              o_valid,
  input  logic                                              i_ready,
  output logic [gp_odata_width-1:0]                         o_data,
  output logic [$clog2(gp_interpolation_factor)-1:0]        o_phase,
  output logic                                              o_last
`ifdef PPI_SERIALIZER_SAT_EN
  ,
  output logic                                              o_sat
`endif
);

  localparam int unsigned L  = gp_interpolation_factor;
  localparam int unsigned PW = gp_phase_width;
  localparam int unsigned OW = gp_odata_width;
  localparam int unsigned CW = $clog2(L);
  localparam logic [CW-1:0] FirstPh = (gp_ccw != 0) ? CW'(L - 1) : '0;
  localparam logic [CW-1:0] LastPh  = (gp_ccw != 0) ? '0 : CW'(L - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e          state_q, state_d;
  logic [PW*L-1:0] frame_q, frame_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   data_q, data_d;
  logic            in_xfer, out_xfer, load;
  logic [PW*L-1:0] src;

  assign in_xfer  = i_valid & o_ready & i_ena;
  assign out_xfer = o_valid & i_ready & i_ena;

`ifdef PPI_SERIALIZER_SAT_EN
  logic sat_q, sat_d;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      frame_q <= '0;
      cnt_q   <= FirstPh;
      data_q  <= '0;
`ifdef PPI_SERIALIZER_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef PPI_SERIALIZER_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_xfer) begin
          state_d = StShift;
          frame_d = i_data;
          cnt_d   = FirstPh;
          load    = 1'b1;
        end
      end
      StShift: begin
        if (out_xfer) begin
          if (!o_last) begin
            cnt_d = (gp_ccw != 0) ? cnt_q - CW'(1) : cnt_q + CW'(1);
            load  = 1'b1;
          end else if (in_xfer) begin
            // Reload on the last phase so back-to-back frames have no bubble.
            frame_d = i_data;
            cnt_d   = FirstPh;
            load    = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_valid = (state_q == StShift);
    o_last  = o_valid & (cnt_q == LastPh);
    o_ready = ~i_rst & i_ena & (~o_valid | (o_last & i_ready));
  end

  // A freshly captured word is sliced straight from the input so it appears one cycle later.
  assign src = in_xfer ? i_data : frame_q;

`ifdef PPI_SERIALIZER_SAT_EN
  logic [PW-1:0] slice, shifted;
  logic          clip;

  always_comb begin
    slice   = src[32'(cnt_d) * PW +: PW];
    shifted = PW'($signed(slice) >>> gp_shift);
    clip    = !((&shifted[PW-1:OW-1]) | ~(|shifted[PW-1:OW-1]));
    data_d  = data_q;
    sat_d   = sat_q;
    if (load) begin
      sat_d  = clip;
      data_d = clip ? {shifted[PW-1], {(OW-1){~shifted[PW-1]}}} : shifted[OW-1:0];
    end
  end

  assign o_sat = sat_q;
`else
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = src[32'(cnt_d) * PW + gp_shift +: OW];
    end
  end
`endif

  assign o_data  = data_q;
  assign o_phase = cnt_q;

endmodule

// File: tb/tb_ppi_serializer.sv
// Bench for ppi_serializer: cw and ccw instances against a queue-based sample model.
module tb_ppi_serializer;

  localparam int L  = 4;
  localparam int PW = 26;
  localparam int OW = 16;
  localparam int SH = 8;

  logic            clk = 1'b0;
  logic            rst, ena, vld, rdy_in;
  logic [PW*L-1:0] din;

  logic            cw_ready, cw_valid, cw_last;
  logic [OW-1:0]   cw_data;
  logic [1:0]      cw_phase;
  logic            ccw_ready, ccw_valid, ccw_last;
  logic [OW-1:0]   ccw_data;
  logic [1:0]      ccw_phase;
`ifdef PPI_SERIALIZER_SAT_EN
  logic            cw_sat, ccw_sat;
`endif

  always #5 clk = ~clk;

  ppi_serializer #(
    .gp_interpolation_factor(L), .gp_phase_width(PW), .gp_odata_width(OW),
    .gp_shift(SH), .gp_ccw(0)
  ) u_cw (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_valid(vld), .i_data(din),
    .o_ready(cw_ready), .o_valid(cw_valid), .i_ready(rdy_in), .o_data(cw_data),
    .o_phase(cw_phase), .o_last(cw_last)
`ifdef PPI_SERIALIZER_SAT_EN
    , .o_sat(cw_sat)
`endif
  );

  ppi_serializer #(
    .gp_interpolation_factor(L), .gp_phase_width(PW), .gp_odata_width(OW),
    .gp_shift(SH), .gp_ccw(1)
  ) u_ccw (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_valid(vld), .i_data(din),
    .o_ready(ccw_ready), .o_valid(ccw_valid), .i_ready(rdy_in), .o_data(ccw_data),
    .o_phase(ccw_phase), .o_last(ccw_last)
`ifdef PPI_SERIALIZER_SAT_EN
    , .o_sat(ccw_sat)
`endif
  );

  typedef struct packed {
    logic [OW-1:0] d;
    logic [1:0]    ph;
    logic          last;
    logic          sat;
  } smp_t;

  typedef struct packed {
    logic [L-1:0][PW-1:0] ph;
    logic [L-1:0][OW-1:0] ew;
    logic [L-1:0][OW-1:0] es;
  } vec_t;

  smp_t          q_cw[$], q_ccw[$];
  logic [OW-1:0] cap_cw[$], cap_ccw[$];
  vec_t          vt[4];
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic smp_t ref_sample(input logic [PW-1:0] p, input int k, input logic last);
    int   v;
    smp_t s;
    v = $signed(p);
    v = v >>> SH;
    s.sat = 1'b0;
`ifdef PPI_SERIALIZER_SAT_EN
    if (v > 32767) begin
      v = 32767;
      s.sat = 1'b1;
    end else if (v < -32768) begin
      v = -32768;
      s.sat = 1'b1;
    end
`endif
    s.d    = v[OW-1:0];
    s.ph   = 2'(k);
    s.last = last;
    return s;
  endfunction

  task automatic push_frame(input logic [PW*L-1:0] d);
    for (int k = 0; k < L; k++) q_cw.push_back(ref_sample(d[k*PW +: PW], k, k == L - 1));
    for (int k = L - 1; k >= 0; k--) q_ccw.push_back(ref_sample(d[k*PW +: PW], k, k == 0));
  endtask

  function automatic logic [PW*L-1:0] rand_word();
    logic [PW*L-1:0] w;
    logic [PW-1:0]   x;
    for (int k = 0; k < L; k++) begin
      x = PW'($urandom) >> $urandom_range(0, 10);
      if ($urandom_range(0, 1) == 1) x = -x;
      w[k*PW +: PW] = x;
    end
    return w;
  endfunction

  // One clock: drive at negedge, compare #1 later, advance the model at posedge.
  task automatic cycle(input logic v, input logic [PW*L-1:0] d, input logic r, input logic e,
                       output logic acc);
    logic vx, rx;
    @(negedge clk);
    vld = v; din = d; rdy_in = r; ena = e;
    #1;
    vx = (q_cw.size() != 0);
    rx = e && (q_cw.size() == 0 || (q_cw.size() == 1 && r));
    chk("cw_valid", 32'(cw_valid), 32'(vx));
    chk("cw_ready", 32'(cw_ready), 32'(rx));
    chk("ccw_valid", 32'(ccw_valid), 32'(vx));
    chk("ccw_ready", 32'(ccw_ready), 32'(rx));
    if (vx) begin
      chk("cw_data", 32'(cw_data), 32'(q_cw[0].d));
      chk("cw_phase", 32'(cw_phase), 32'(q_cw[0].ph));
      chk("cw_last", 32'(cw_last), 32'(q_cw[0].last));
      chk("ccw_data", 32'(ccw_data), 32'(q_ccw[0].d));
      chk("ccw_phase", 32'(ccw_phase), 32'(q_ccw[0].ph));
      chk("ccw_last", 32'(ccw_last), 32'(q_ccw[0].last));
`ifdef PPI_SERIALIZER_SAT_EN
      chk("cw_sat", 32'(cw_sat), 32'(q_cw[0].sat));
      chk("ccw_sat", 32'(ccw_sat), 32'(q_ccw[0].sat));
`endif
    end
    acc = v && rx;
    if (vx && r && e) begin
      cap_cw.push_back(cw_data);
      cap_ccw.push_back(ccw_data);
    end
    @(posedge clk);
    if (vx && r && e) begin
      void'(q_cw.pop_front());
      void'(q_ccw.pop_front());
    end
    if (acc) push_frame(d);
  endtask

  task automatic chk_reset();
    chk("rst_cw_valid", 32'(cw_valid), 32'd0);
    chk("rst_cw_ready", 32'(cw_ready), 32'd0);
    chk("rst_cw_data", 32'(cw_data), 32'd0);
    chk("rst_cw_phase", 32'(cw_phase), 32'd0);
    chk("rst_cw_last", 32'(cw_last), 32'd0);
    chk("rst_ccw_valid", 32'(ccw_valid), 32'd0);
    chk("rst_ccw_ready", 32'(ccw_ready), 32'd0);
    chk("rst_ccw_data", 32'(ccw_data), 32'd0);
    chk("rst_ccw_phase", 32'(ccw_phase), 32'd3);
    chk("rst_ccw_last", 32'(ccw_last), 32'd0);
`ifdef PPI_SERIALIZER_SAT_EN
    chk("rst_cw_sat", 32'(cw_sat), 32'd0);
    chk("rst_ccw_sat", 32'(ccw_sat), 32'd0);
`endif
  endtask

  initial begin
    logic            acc, hold;
    logic [PW*L-1:0] word;
    logic [OW-1:0]   e_cw, e_ccw;
    int              sent;

    // Phase k is element [k]; concatenations list phase 3 first.
    vt[0].ph = {26'h07FFF00, 26'h3FFFF00, 26'h0000200, 26'h0000100};
    vt[0].ew = {16'h7FFF, 16'hFFFF, 16'h0002, 16'h0001};
    vt[0].es = {16'h7FFF, 16'hFFFF, 16'h0002, 16'h0001};
    vt[1].ph = {26'h0000080, 26'h2000000, 26'h00000FF, 26'h1000000};
    vt[1].ew = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[1].es = {16'h0000, 16'h8000, 16'h0000, 16'h7FFF};
    vt[2].ph = {26'h0FFFF00, 26'h3FF8000, 26'h0008000, 26'h3FFFFFF};
    vt[2].ew = {16'hFFFF, 16'hFF80, 16'h0080, 16'hFFFF};
    vt[2].es = {16'h7FFF, 16'hFF80, 16'h0080, 16'hFFFF};
    vt[3].ph = {26'h37FFFFF, 26'h3800000, 26'h0800000, 26'h07FFFFF};
    vt[3].ew = {16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF};
    vt[3].es = {16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF};

    rst = 1'b1; ena = 1'b1; vld = 1'b0; rdy_in = 1'b1; din = '0;
    #12;
    chk_reset();
    @(negedge clk);
    rst = 1'b0;

    // Table frames, each sent alone with i_ready held high.
    for (int i = 0; i < 4; i++) begin
      cap_cw.delete();
      cap_ccw.delete();
      cycle(1'b1, vt[i].ph, 1'b1, 1'b1, acc);
      repeat (L + 1) cycle(1'b0, '0, 1'b1, 1'b1, acc);
      for (int k = 0; k < L; k++) begin
`ifdef PPI_SERIALIZER_SAT_EN
        e_cw  = vt[i].es[k];
        e_ccw = vt[i].es[L-1-k];
`else
        e_cw  = vt[i].ew[k];
        e_ccw = vt[i].ew[L-1-k];
`endif
        chk($sformatf("tbl%0d_cw%0d", i, k), 32'(cap_cw[k]), 32'(e_cw));
        chk($sformatf("tbl%0d_ccw%0d", i, k), 32'(cap_ccw[k]), 32'(e_ccw));
      end
    end

    // Three frames back to back with i_valid held high.
    sent = 0;
    word = rand_word();
    repeat (3 * L + 2) begin
      cycle(sent < 3, word, 1'b1, 1'b1, acc);
      if (acc) begin
        sent++;
        word = rand_word();
      end
    end

    // Back-pressure pattern inside one frame.
    cycle(1'b1, rand_word(), 1'b1, 1'b1, acc);
    foreach (vt[0].ew[i]) cycle(1'b0, '0, (i == 0 || i == 3), 1'b1, acc);
    repeat (L) cycle(1'b0, '0, 1'b1, 1'b1, acc);

    // Enable low for three cycles mid-frame while a new word is offered.
    cycle(1'b1, rand_word(), 1'b1, 1'b1, acc);
    cycle(1'b0, '0, 1'b1, 1'b1, acc);
    word = rand_word();
    repeat (3) cycle(1'b1, word, 1'b1, 1'b0, acc);
    repeat (2 * L + 1) cycle(1'b0, '0, 1'b1, 1'b1, acc);

    // Asynchronous reset in the middle of a frame.
    cycle(1'b1, rand_word(), 1'b1, 1'b1, acc);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b1, acc);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset();
    q_cw.delete();
    q_ccw.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b1, acc);

    // Randomised traffic; the upstream holds its word until it is accepted.
    word = rand_word();
    repeat (400) begin
      logic v;
      v = ($urandom_range(0, 9) < 6);
      cycle(v, word, $urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, acc);
      hold = v && !acc;
      if (!hold) word = rand_word();
      while (hold) begin
        cycle(1'b1, word, $urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, acc);
        hold = !acc;
      end
      word = rand_word();
    end
    repeat (3 * L) cycle(1'b0, '0, 1'b1, 1'b1, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
